ym_cnt_ring: RTL

- Channel-multiplexed counter cell: CHANNELS independent DATA_WIDTH-bit counters share one adder. They are stored in a two-phase (c1/c2) recirculating shift ring, as in YM-style time-slot hardware.
- Generalises the single-slot counter cells. Adds configurable ring depth, a built-in slot counter with sync, up/down counting, load, clear, saturation and a terminal-count flag.
- Used for per-channel/per-operator timers and phase/envelope-style counters.

---
 rtl/ym_cnt_ring.sv | 89 ++++++++
 1 files changed

// File: rtl/ym_cnt_ring.sv
// ym_cnt_ring: time-slot multiplexed counter bank.
// CHANNELS counters of DATA_WIDTH bits recirculate through a two-phase
// (c1/c2) shift ring and share a single add/subtract stage at the ring head.
// A slot counter numbers the head position; sync renumbers without moving data.
module ym_cnt_ring #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 6,
  parameter int SATURATE   = 0,
  localparam int SW        = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                  MCLK,
  input  logic                  reset_n,
  input  logic                  c1,
  input  logic                  c2,
  input  logic                  sync,
  input  logic                  c_in,
  input  logic                  dec,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] val,
  output logic [SW-1:0]         slot,
  output logic                  c_out,
  output logic                  tc
);

  // Ring storage: element CHANNELS-1 of stage 2 is the head presented on val.
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] r_s1;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] r_s2;
  logic [SW-1:0]                       r_slot;

  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0] w_step;
  logic [DATA_WIDTH-1:0] w_nxt;
  logic                  w_at_lim;
  logic                  w_cout;

  assign w_head = r_s2[CHANNELS-1];

  // Shared adder: select base, count up/down, apply saturation and clear.
  always_comb begin
    w_base   = load ? load_val : w_head;
    w_at_lim = dec ? (w_base == '0) : (w_base == '1);
    w_cout   = c_in & w_at_lim;
    w_step   = dec ? (w_base - DATA_WIDTH'(c_in)) : (w_base + DATA_WIDTH'(c_in));
    if (clr) begin
      w_nxt = '0;
    end else if ((SATURATE != 0) && w_cout) begin
      w_nxt = w_base;
    end else begin
      w_nxt = w_step;
    end
  end

  // Phase 1 shifts the ring and inserts the new value; phase 2 commits stage 1.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      if (c1) begin
        r_s1 <= {r_s2[CHANNELS-2:0], w_nxt};
      end
      if (c2) begin
        r_s2 <= r_s1;
      end
    end
  end

  // Slot counter advances with phase 2; sync forces the next slot to zero.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '0;
    end else if (c2) begin
      if (sync || (r_slot == SW'(CHANNELS - 1))) begin
        r_slot <= '0;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  assign val   = w_head;
  assign slot  = r_slot;
  assign c_out = w_cout;
  assign tc    = dec ? (w_head == '0) : (w_head == '1);

endmodule
